// File: rtl/round_sequencer.sv
// rtl/round_sequencer.sv - runs a programmed number of downstream counter wraps with pause and abort
module round_sequencer #(
  parameter int RW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic [RW-1:0] rounds_i,
  input  logic          pause_i,
  input  logic          abort_i,
  input  logic          cnt_done_i,
  output logic          cnt_enable_o,
  output logic          busy_o,
  output logic [RW-1:0] round_idx_o,
  output logic          finished_o,
  output logic          aborted_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [RW-1:0] rounds_q, rounds_d;
  logic [RW-1:0] round_idx_q, round_idx_d;
  logic          aborted_q, aborted_d;

  logic [RW-1:0] idx_inc;
  logic          terminal;

  // The compare is done on the incremented index, so a run never needs the wrapped value.
  assign idx_inc  = round_idx_q + RW'(1);
  assign terminal = cnt_done_i && (idx_inc == rounds_q);

  // State and run bookkeeping registers; reset abandons any run without pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      rounds_q    <= '0;
      round_idx_q <= '0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rounds_q    <= rounds_d;
      round_idx_q <= round_idx_d;
      aborted_q   <= aborted_d;
    end
  end

  // Next-state and output decode; abort outranks a coincident wrap pulse.
  always_comb begin
    state_d      = state_q;
    rounds_d     = rounds_q;
    round_idx_d  = round_idx_q;
    aborted_d    = 1'b0;
    cnt_enable_o = 1'b0;
    busy_o       = 1'b1;
    finished_o   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          rounds_d    = rounds_i;
          round_idx_d = '0;
          state_d     = (rounds_i != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN, S_PAUSED: begin
        // The counter is stopped in the very cycle of the last wrap so it rests at zero.
        cnt_enable_o = (state_q == S_RUN) && !terminal;
        if (abort_i) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else begin
          // A wrap already in flight when pausing still counts.
          if (cnt_done_i) begin
            round_idx_d = idx_inc;
          end
          if (terminal) begin
            state_d = S_DONE;
          end else if (pause_i) begin
            state_d = S_PAUSED;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_DONE: begin
        finished_o = 1'b1;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign round_idx_o = round_idx_q;
  assign aborted_o   = aborted_q;

endmodule

// File: tb/tb_round_sequencer.sv
// tb/tb_round_sequencer.sv - randomized self-checking bench for round_sequencer
module tb_round_sequencer;
  localparam int RW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_i;
  logic [RW-1:0] rounds_i;
  logic          pause_i;
  logic          abort_i;
  logic          cnt_done;
  logic          cnt_enable;
  logic          busy;
  logic [RW-1:0] round_idx;
  logic          finished;
  logic          aborted;

  int   ctr_n = 8;
  logic ctr_clr = 1'b0;
  int   ctr_out;

  int n_checks = 0;
  int n_fail = 0;

  int r_en, r_fin, r_abt, r_idx_err, r_fin_cyc, r_term_cyc, r_abt_cyc, r_abort_cyc;
  int r_paused_dones, r_timeout, r_ctr_after, r_idx_after;
  logic r_busy_pulse, r_busy_after, r_en_after;

  always #5 clk = ~clk;

  round_sequencer #(.RW(RW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start_i),
    .rounds_i    (rounds_i),
    .pause_i     (pause_i),
    .abort_i     (abort_i),
    .cnt_done_i  (cnt_done),
    .cnt_enable_o(cnt_enable),
    .busy_o      (busy),
    .round_idx_o (round_idx),
    .finished_o  (finished),
    .aborted_o   (aborted)
  );

  // Downstream modulo-N counter: registered wrap pulse one cycle after the last enabled count.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctr_out  <= 0;
      cnt_done <= 1'b0;
    end else if (ctr_clr) begin
      ctr_out  <= 0;
      cnt_done <= 1'b0;
    end else begin
      cnt_done <= cnt_enable && (ctr_out == ctr_n - 1);
      if (cnt_enable) ctr_out <= (ctr_out == ctr_n - 1) ? 0 : ctr_out + 1;
    end
  end

  task automatic clear_counter(input int n);
    ctr_clr = 1'b1;
    ctr_n   = n;
    @(posedge clk); #1;
    ctr_clr = 1'b0;
  endtask

  // Runs one start request to completion; expected round index follows the wrap pulses seen.
  task automatic drive_run(input int r, input bit hold, input int next_r, input int pause_pct,
                           input bit pause_trig, input int pause_len, input int abort_on_done,
                           input int abort_cycle);
    logic [RW-1:0] exp_idx;
    bit exp_active;
    bit stop;
    bit pause_used;
    int pause_rem;
    r_en = 0; r_fin = 0; r_abt = 0; r_idx_err = 0; r_fin_cyc = -1; r_term_cyc = -1;
    r_abt_cyc = -1; r_abort_cyc = -1; r_paused_dones = 0; r_timeout = 0; r_busy_pulse = 1'b0;
    start_i = 1'b1; rounds_i = r[RW-1:0]; pause_i = 1'b0; abort_i = 1'b0;
    @(posedge clk); #1;
    start_i = hold;
    exp_idx = '0; exp_active = (r != 0); stop = 0; pause_used = 0; pause_rem = 0;
    for (int cyc = 0; cyc < 2000 && !stop; cyc++) begin
      rounds_i = RW'($urandom);
      if (pause_rem > 0) begin
        pause_i = 1'b1;
        pause_rem--;
      end else if (pause_trig && !pause_used && ctr_out == ctr_n - 1 && cnt_enable) begin
        pause_i = 1'b1;
        pause_used = 1;
        pause_rem = pause_len - 1;
      end else begin
        pause_i = ($urandom_range(0, 99) < pause_pct);
      end
      abort_i = exp_active && ((abort_on_done > 0 && cnt_done && int'(exp_idx) + 1 == abort_on_done)
                               || cyc == abort_cycle);
      @(negedge clk);
      if (round_idx !== exp_idx) r_idx_err++;
      if (cnt_enable) r_en++;
      if (finished) begin r_fin++; r_fin_cyc = cyc; r_busy_pulse = busy; end
      if (aborted) begin r_abt++; r_abt_cyc = cyc; r_busy_pulse = busy; end
      if (abort_i) begin
        exp_active = 0;
        r_abort_cyc = cyc;
      end else if (exp_active && cnt_done) begin
        if (!cnt_enable && int'(exp_idx) + 1 != r) r_paused_dones++;
        exp_idx++;
        if (int'(exp_idx) == r) begin exp_active = 0; r_term_cyc = cyc; end
      end
      if (r_fin > 0 || r_abt > 0) stop = 1;
      if (!exp_active && cyc > r_term_cyc + 3 && cyc > r_abort_cyc + 3) stop = 1;
      @(posedge clk); #1;
    end
    if (!stop) r_timeout = 1;
    pause_i = 1'b0; abort_i = 1'b0; start_i = hold;
    rounds_i = hold ? next_r[RW-1:0] : RW'($urandom);
    @(negedge clk);
    r_busy_after = busy; r_en_after = cnt_enable; r_ctr_after = ctr_out; r_idx_after = int'(round_idx);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_i = 1'b1; rounds_i = '0; pause_i = 1'b0; abort_i = 1'b0;
    #12;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (cnt_enable !== 1'b0) begin n_fail++; $display("FAIL reset_enable: got %b expected 0", cnt_enable); end
    n_checks++; if (round_idx !== '0) begin n_fail++; $display("FAIL reset_idx: got %0d expected 0", round_idx); end
    n_checks++; if (finished !== 1'b0) begin n_fail++; $display("FAIL reset_finished: got %b expected 0", finished); end
    n_checks++; if (aborted !== 1'b0) begin n_fail++; $display("FAIL reset_aborted: got %b expected 0", aborted); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1; start_i = 1'b0;
    @(negedge clk);
    n_checks++; if (finished !== 1'b1) begin n_fail++; $display("FAIL first_edge_finished: got %b expected 1", finished); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL first_edge_busy: got %b expected 1", busy); end
    @(negedge clk);
    n_checks++; if (finished !== 1'b0) begin n_fail++; $display("FAIL first_edge_finished_drop: got %b expected 0", finished); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL first_edge_idle: got %b expected 0", busy); end
  endtask

  task automatic test_three_rounds();
    clear_counter(8);
    drive_run(3, 0, 0, 0, 0, 0, 0, -1);
    n_checks++; if (r_en !== 24) begin n_fail++; $display("FAIL three_enable_cycles: got %0d expected 24", r_en); end
    n_checks++; if (r_fin !== 1) begin n_fail++; $display("FAIL three_finished_count: got %0d expected 1", r_fin); end
    n_checks++; if (r_fin_cyc !== r_term_cyc + 1) begin n_fail++; $display("FAIL three_finished_timing: got %0d expected %0d", r_fin_cyc, r_term_cyc + 1); end
    n_checks++; if (r_abt !== 0) begin n_fail++; $display("FAIL three_aborted_count: got %0d expected 0", r_abt); end
    n_checks++; if (r_idx_err !== 0) begin n_fail++; $display("FAIL three_idx_sequence: got %0d errors expected 0", r_idx_err); end
    n_checks++; if (r_idx_after !== 3) begin n_fail++; $display("FAIL three_idx_final: got %0d expected 3", r_idx_after); end
    n_checks++; if (r_ctr_after !== 0) begin n_fail++; $display("FAIL three_counter_rest: got %0d expected 0", r_ctr_after); end
    n_checks++; if (r_busy_pulse !== 1'b1) begin n_fail++; $display("FAIL three_busy_in_done: got %b expected 1", r_busy_pulse); end
    n_checks++; if (r_busy_after !== 1'b0) begin n_fail++; $display("FAIL three_busy_after: got %b expected 0", r_busy_after); end
    n_checks++; if (r_timeout !== 0) begin n_fail++; $display("FAIL three_timeout: got %0d expected 0", r_timeout); end
  endtask

  task automatic test_zero_rounds();
    clear_counter(8);
    drive_run(0, 0, 0, 0, 0, 0, 0, -1);
    n_checks++; if (r_fin !== 1) begin n_fail++; $display("FAIL zero_finished_count: got %0d expected 1", r_fin); end
    n_checks++; if (r_fin_cyc !== 0) begin n_fail++; $display("FAIL zero_finished_timing: got %0d expected 0", r_fin_cyc); end
    n_checks++; if (r_en !== 0) begin n_fail++; $display("FAIL zero_enable_cycles: got %0d expected 0", r_en); end
    n_checks++; if (r_idx_after !== 0) begin n_fail++; $display("FAIL zero_idx_final: got %0d expected 0", r_idx_after); end
    n_checks++; if (r_busy_after !== 1'b0) begin n_fail++; $display("FAIL zero_busy_after: got %b expected 0", r_busy_after); end
  endtask

  task automatic test_pause_pending();
    clear_counter(8);
    drive_run(2, 0, 0, 0, 1, 5, 0, -1);
    n_checks++; if (r_en !== 16) begin n_fail++; $display("FAIL pause_enable_cycles: got %0d expected 16", r_en); end
    n_checks++; if (r_fin !== 1) begin n_fail++; $display("FAIL pause_finished_count: got %0d expected 1", r_fin); end
    n_checks++; if (r_paused_dones < 1) begin n_fail++; $display("FAIL pause_pulse_in_paused: got %0d expected at least 1", r_paused_dones); end
    n_checks++; if (r_idx_err !== 0) begin n_fail++; $display("FAIL pause_idx_sequence: got %0d errors expected 0", r_idx_err); end
    n_checks++; if (r_idx_after !== 2) begin n_fail++; $display("FAIL pause_idx_final: got %0d expected 2", r_idx_after); end
  endtask

  task automatic test_abort_second_done();
    clear_counter(8);
    drive_run(4, 0, 0, 0, 0, 0, 2, -1);
    n_checks++; if (r_abt !== 1) begin n_fail++; $display("FAIL abort_pulse_count: got %0d expected 1", r_abt); end
    n_checks++; if (r_abt_cyc !== r_abort_cyc + 1) begin n_fail++; $display("FAIL abort_pulse_timing: got %0d expected %0d", r_abt_cyc, r_abort_cyc + 1); end
    n_checks++; if (r_fin !== 0) begin n_fail++; $display("FAIL abort_no_finished: got %0d expected 0", r_fin); end
    n_checks++; if (r_idx_after !== 1) begin n_fail++; $display("FAIL abort_idx_final: got %0d expected 1", r_idx_after); end
    n_checks++; if (r_busy_pulse !== 1'b0) begin n_fail++; $display("FAIL abort_busy_at_pulse: got %b expected 0", r_busy_pulse); end
    n_checks++; if (r_en_after !== 1'b0) begin n_fail++; $display("FAIL abort_enable_after: got %b expected 0", r_en_after); end
    n_checks++; if (r_busy_after !== 1'b0) begin n_fail++; $display("FAIL abort_busy_after: got %b expected 0", r_busy_after); end
  endtask

  task automatic test_start_held();
    clear_counter(8);
    drive_run(2, 1, 3, 0, 0, 0, 0, -1);
    n_checks++; if (r_en !== 16) begin n_fail++; $display("FAIL held_enable_cycles: got %0d expected 16", r_en); end
    n_checks++; if (r_fin !== 1) begin n_fail++; $display("FAIL held_finished_count: got %0d expected 1", r_fin); end
    n_checks++; if (r_busy_after !== 1'b0) begin n_fail++; $display("FAIL held_idle_after_done: got %b expected 0", r_busy_after); end
    drive_run(3, 0, 0, 0, 0, 0, 0, -1);
    n_checks++; if (r_en !== 24) begin n_fail++; $display("FAIL held_reaccept_enable: got %0d expected 24", r_en); end
    n_checks++; if (r_idx_after !== 3) begin n_fail++; $display("FAIL held_reaccept_idx: got %0d expected 3", r_idx_after); end
    n_checks++; if (r_fin !== 1) begin n_fail++; $display("FAIL held_reaccept_finished: got %0d expected 1", r_fin); end
  endtask

  task automatic test_random_runs();
    int n, r, pct, acyc;
    for (int run = 0; run < 25; run++) begin
      n    = $urandom_range(2, 8);
      r    = $urandom_range(0, 5);
      pct  = $urandom_range(0, 40);
      acyc = ($urandom_range(0, 2) == 0) ? $urandom_range(0, r * n) : -1;
      clear_counter(n);
      drive_run(r, 0, 0, pct, 0, 0, 0, acyc);
      if (r_abort_cyc >= 0) begin
        n_checks++; if (r_abt !== 1) begin n_fail++; $display("FAIL rand%0d_abort_count: got %0d expected 1", run, r_abt); end
        n_checks++; if (r_fin !== 0) begin n_fail++; $display("FAIL rand%0d_abort_no_finished: got %0d expected 0", run, r_fin); end
        n_checks++; if (r_abt_cyc !== r_abort_cyc + 1) begin n_fail++; $display("FAIL rand%0d_abort_timing: got %0d expected %0d", run, r_abt_cyc, r_abort_cyc + 1); end
      end else begin
        n_checks++; if (r_fin !== 1) begin n_fail++; $display("FAIL rand%0d_finished_count: got %0d expected 1", run, r_fin); end
        n_checks++; if (r_abt !== 0) begin n_fail++; $display("FAIL rand%0d_aborted_count: got %0d expected 0", run, r_abt); end
        n_checks++; if (r_en !== r * n) begin n_fail++; $display("FAIL rand%0d_enable_cycles: got %0d expected %0d", run, r_en, r * n); end
        n_checks++; if (r_fin_cyc !== r_term_cyc + 1) begin n_fail++; $display("FAIL rand%0d_finished_timing: got %0d expected %0d", run, r_fin_cyc, r_term_cyc + 1); end
        n_checks++; if (r_ctr_after !== 0) begin n_fail++; $display("FAIL rand%0d_counter_rest: got %0d expected 0", run, r_ctr_after); end
      end
      n_checks++; if (r_idx_err !== 0) begin n_fail++; $display("FAIL rand%0d_idx_sequence: got %0d errors expected 0", run, r_idx_err); end
      n_checks++; if (r_busy_after !== 1'b0) begin n_fail++; $display("FAIL rand%0d_busy_after: got %b expected 0", run, r_busy_after); end
      n_checks++; if (r_en_after !== 1'b0) begin n_fail++; $display("FAIL rand%0d_enable_after: got %b expected 0", run, r_en_after); end
      n_checks++; if (r_timeout !== 0) begin n_fail++; $display("FAIL rand%0d_timeout: got %0d expected 0", run, r_timeout); end
    end
  endtask

  task automatic test_reset_midrun();
    clear_counter(8);
    start_i = 1'b1; rounds_i = 8'd3;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (12) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++; if (cnt_enable !== 1'b0) begin n_fail++; $display("FAIL midreset_enable: got %b expected 0", cnt_enable); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    n_checks++; if (round_idx !== '0) begin n_fail++; $display("FAIL midreset_idx: got %0d expected 0", round_idx); end
    n_checks++; if (finished !== 1'b0) begin n_fail++; $display("FAIL midreset_finished: got %b expected 0", finished); end
    n_checks++; if (aborted !== 1'b0) begin n_fail++; $display("FAIL midreset_aborted: got %b expected 0", aborted); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if ((finished | aborted | busy) !== 1'b0) begin n_fail++; $display("FAIL midreset_quiet%0d: got fin=%b abt=%b busy=%b expected all 0", i, finished, aborted, busy); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_three_rounds();
    test_zero_rounds();
    test_pause_pending();
    test_abort_second_done();
    test_start_held();
    test_random_runs();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/round_sequencer.md
ROUND_SEQUENCER -- requirements
Module: round_sequencer

Interface
REQ-001 Parameter RW, default 8, width of the round-count input and the round index.
REQ-002 clk  input  1  rising-edge clock; sole clock of the block.
REQ-003 reset  input  1  asynchronous, active-low reset; block held in reset while 0.
REQ-004 start  input  1  run request; accepted only in IDLE.
REQ-005 rounds  input  RW  number of counter wraps to run; sampled only on start accept.
REQ-006 pause  input  1  level; suspends counting while 1.
REQ-007 abort  input  1  cancels an active run.
REQ-008 cnt_done  input  1  single-cycle wrap pulse from the downstream modulo-N counter.
REQ-009 cnt_enable  output  1  enable to the downstream counter.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 round_idx  output  RW  count of cnt_done pulses taken in the current or last run.
REQ-012 finished  output  1  single-cycle pulse on normal run completion.
REQ-013 aborted  output  1  single-cycle pulse on abort.

Function
REQ-014 FSM states SHALL be IDLE, RUN, PAUSED, DONE; all transitions on rising clk edge.
REQ-015 IDLE with start=1: rounds_q <= rounds, round_idx <= 0; go to RUN if rounds != 0, else to DONE.
REQ-016 start SHALL be ignored in RUN, PAUSED and DONE; abort SHALL be ignored in IDLE and DONE.
REQ-017 RUN with pause=1 (no abort, no terminal cnt_done) -> PAUSED; PAUSED with pause=0 -> RUN.
REQ-018 In RUN or PAUSED, cnt_done=1 increments round_idx by 1 (modulo 2^RW arithmetic not reachable since compare precedes wrap).
REQ-019 Terminal pulse: cnt_done=1 while round_idx+1 == rounds_q -> DONE, regardless of pause.
REQ-020 cnt_done arriving in PAUSED (pulse in flight when enable dropped) SHALL be counted identically to RUN.
REQ-021 cnt_done in IDLE or DONE SHALL be ignored; round_idx unchanged.
REQ-022 abort=1 in RUN or PAUSED -> IDLE, aborted=1 next cycle; abort has priority over cnt_done in the same cycle (pulse not counted); round_idx holds.
REQ-023 DONE lasts exactly one cycle, then -> IDLE; finished is 1 during exactly that cycle.
REQ-024 cnt_enable SHALL be combinational: 1 iff state==RUN and not (cnt_done=1 and round_idx+1 == rounds_q); this stops the counter on the terminal wrap with out at 0.
REQ-025 busy SHALL be 1 in RUN, PAUSED, DONE; 0 in IDLE.
REQ-026 aborted SHALL be a registered single-cycle pulse; finished derived from DONE state.
REQ-027 round_idx SHALL hold its final value in IDLE until the next accepted start.

Reset
REQ-028 reset=0 SHALL immediately force state IDLE, rounds_q 0, round_idx 0, aborted 0; hence cnt_enable 0, busy 0, finished 0.
REQ-029 Reset asserted mid-run SHALL abandon the run with no finished or aborted pulse.
REQ-030 First start accept is possible on the first rising edge after reset deasserts.

Verification
REQ-031 rounds=3, start pulse, downstream counter N=8, pause=0 -> cnt_enable high exactly 24 cycles, round_idx 1,2,3, one finished pulse, counter out=0 afterwards, busy low next cycle.
REQ-032 rounds=0, start -> DONE next edge, finished one cycle, cnt_enable never high, round_idx=0.
REQ-033 rounds=2, pause=1 for 5 cycles mid-round, pause asserted the cycle a cnt_done is pending -> pulse counted in PAUSED, total enabled cycles still 16, finished once.
REQ-034 rounds=4, abort coincident with second cnt_done -> aborted pulse, round_idx=1, no finished, cnt_enable 0, busy 0.
REQ-035 start held high during run and in DONE -> no restart until IDLE; start still high in IDLE re-accepts with new rounds value.
REQ-036 reset=0 asynchronously mid-RUN (between clock edges) -> cnt_enable, busy, round_idx 0 immediately; no output pulses.
